// File: rtl/in_port_pkg.sv
// Shared constants and helpers for the Mini SRC CPU input port FIFO.
package in_port_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int CNT_W_DEF = clog2(DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

endpackage

// File: rtl/in_port_edge_det.sv
// Rising-edge detector for the external write strobe; history resets high so
// a strobe already asserted through clear is not counted as a new word.
module in_port_edge_det (
  input  logic clock,
  input  logic clear,
  input  logic strobe,
  output logic push_req
);

  logic strobe_q;

  always_ff @(posedge clock) begin
    if (clear) strobe_q <= 1'b1;
    else       strobe_q <= strobe;
  end

  assign push_req = strobe & ~strobe_q;

endmodule

// File: rtl/in_port_fifo.sv
// Input port FIFO: external strobe edges push words, the CPU pops via InPortRead.
// Build option INPORT_OVF_STICKY_EN makes InPortOverflow sticky until clear.
module in_port_fifo
  import in_port_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        ExtData,
  input  logic                     ExtStrobe,
  input  logic                     InPortRead,
  output logic [DATA_W-1:0]        BusMuxIn_InPort,
  output logic                     InPortEmpty,
  output logic                     InPortFull,
  output logic [clog2(DEPTH):0]    InPortCount,
  output logic                     InPortOverflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ovf;
  logic              push_req, do_push, do_pop, drop;
  fifo_op_e          op;

  in_port_edge_det u_edge (
    .clock    (clock),
    .clear    (clear),
    .strobe   (ExtStrobe),
    .push_req (push_req)
  );

  assign InPortEmpty = (count == '0);
  assign InPortFull  = (count == CNT_W'(DEPTH));

  // When full, a same-cycle pop frees the slot the push lands in.
  assign do_pop  = InPortRead & ~InPortEmpty;
  assign do_push = push_req & (~InPortFull | do_pop);
  assign drop    = push_req & InPortFull & ~do_pop;

  always_comb begin
    op        = fifo_op_e'({do_pop, do_push});
    count_nxt = count;
    case (op)
      OP_PUSH: count_nxt = count + CNT_W'(1);
      OP_POP:  count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
`ifdef INPORT_OVF_STICKY_EN
      ovf <= ovf | drop;
`else
      ovf <= drop;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!clear && do_push) mem[wr_ptr] <= ExtData;
  end

  assign BusMuxIn_InPort = InPortEmpty ? '0 : mem[rd_ptr];
  assign InPortCount     = count;
  assign InPortOverflow  = ovf;

endmodule

// File: tb/tb_in_port_fifo.sv
// Scoreboard bench for in_port_fifo: a queue-based reference model predicts the
// visible state after every clock edge; a separate monitor compares it.
module tb_in_port_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [DATA_W-1:0] head;
    logic              empty;
    logic              full;
    int                count;
    logic              ovf;
  } exp_t;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] ExtData = '0;
  logic              ExtStrobe = 1'b0;
  logic              InPortRead = 1'b0;
  logic [DATA_W-1:0] BusMuxIn_InPort;
  logic              InPortEmpty, InPortFull, InPortOverflow;
  logic [2:0]        InPortCount;

  in_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .clear           (clear),
    .ExtData         (ExtData),
    .ExtStrobe       (ExtStrobe),
    .InPortRead      (InPortRead),
    .BusMuxIn_InPort (BusMuxIn_InPort),
    .InPortEmpty     (InPortEmpty),
    .InPortFull      (InPortFull),
    .InPortCount     (InPortCount),
    .InPortOverflow  (InPortOverflow)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [DATA_W-1:0] words[$];
  logic              prev_strobe = 1'b1;
  logic              m_ovf = 1'b0;
  exp_t              exp_q[$];

  int  vectors = 0;
  int  miscompares = 0;
  bit  stim_done = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and predict the state after the next rising edge.
  task automatic step(input logic s, input logic [DATA_W-1:0] d, input logic r, input logic c);
    exp_t e;
    bit   edge_seen, dropped;
    @(negedge clock);
    ExtStrobe = s; ExtData = d; InPortRead = r; clear = c;
    if (c) begin
      words.delete();
      m_ovf = 1'b0;
      prev_strobe = 1'b1;
    end else begin
      edge_seen = s && !prev_strobe;
      prev_strobe = s;
      dropped = 0;
      if (r && words.size() > 0) void'(words.pop_front());
      if (edge_seen) begin
        if (words.size() < DEPTH) words.push_back(d);
        else dropped = 1;
      end
`ifdef INPORT_OVF_STICKY_EN
      m_ovf = m_ovf | dropped;
`else
      m_ovf = dropped;
`endif
    end
    e.head  = (words.size() > 0) ? words[0] : '0;
    e.empty = (words.size() == 0);
    e.full  = (words.size() == DEPTH);
    e.count = words.size();
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the DUT just after every rising edge.
  initial begin
    exp_t e;
    while (!stim_done || exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("head",  BusMuxIn_InPort, e.head);
        chk("empty", DATA_W'(InPortEmpty), DATA_W'(e.empty));
        chk("full",  DATA_W'(InPortFull), DATA_W'(e.full));
        chk("count", DATA_W'(InPortCount), DATA_W'(e.count));
        chk("ovf",   DATA_W'(InPortOverflow), DATA_W'(e.ovf));
      end
    end
  end

  initial begin
    // Reset, then pop while empty
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Ordered fill and drain
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Fill, overflow, then push+pop while full
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i);
    push_word(32'hA4);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hB4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Simultaneous push and pop while empty
    step(1'b1, 32'hD0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // Held strobe, then clear while strobe still high
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + i, 1'b0, 1'b0);
    step(1'b1, 32'hE8, 1'b0, 1'b1);
    step(1'b1, 32'hE9, 1'b0, 1'b1);
    step(1'b1, 32'hEA, 1'b0, 1'b0);
    step(1'b1, 32'hEB, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hEC, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // Wrap-around with alternating push/pop
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hC0 + i, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    // Random traffic
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 99) == 0));
    stim_done = 1;
    repeat (4) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/in_port_fifo.md
Name: in_port_fifo

Overview:
- Input Port for the Mini SRC CPU. Mirror of the output port: moves 32-bit words from an external device into the CPU.
- External device presents a word on ExtData and raises ExtStrobe. Each rising edge of ExtStrobe pushes one word into a DEPTH-entry FIFO.
- The CPU datapath reads the head word through the bus mux input and pops it with InPortRead.
- Status flags (empty, full, count, overflow) are exposed for polling by the control unit.

Parameters:
- DATA_W, 32, word width; must match the CPU bus.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- clear  in  1  synchronous, active-high reset.
- ExtData  in  DATA_W  data from the external device; sampled in the cycle a strobe edge is detected.
- ExtStrobe  in  1  external write strobe, level; each 0->1 transition is one word. Synchronous to clock.
- InPortRead  in  1  CPU pop request, one pulse per word consumed.
- BusMuxIn_InPort  out  DATA_W  head word to the bus mux; 0 when empty.
- InPortEmpty  out  1  FIFO holds no words.
- InPortFull  out  1  FIFO holds DEPTH words.
- InPortCount  out  log2(DEPTH)+1  number of words held.
- InPortOverflow  out  1  a push was dropped (see Optional Feature).

Behaviour:
- Reset:
  - clear is synchronous and active-high. On the first rising clock edge with clear=1: read and write pointers = 0, count = 0, overflow = 0, strobe history register = 1.
  - Outputs after reset: BusMuxIn_InPort=0, InPortEmpty=1, InPortFull=0, InPortCount=0, InPortOverflow=0.
  - Reset overrides all push and pop activity in the same cycle.
  - Strobe history resets to 1, so a strobe held high through clear is not counted as a new word. A fresh 0->1 transition is required.
- Edge detect:
  - push_req = ExtStrobe & ~strobe_q.
  - strobe_q <= ExtStrobe every cycle, except during clear.
- Push: on push_req with the FIFO not full (or full with a simultaneous pop):
  - mem[wr_ptr] <= ExtData; wr_ptr increments, modulo DEPTH.
- Pop: on InPortRead with the FIFO not empty, rd_ptr increments, modulo DEPTH.
- Ignored operations:
  - A pop while empty is ignored; no state change.
- Full boundary:
  - push_req while full with no pop: the word is dropped, pointers and count are unchanged, and the overflow event fires.
  - push_req while full with a pop in the same cycle: both occur, count stays DEPTH, no overflow.
- Empty boundary:
  - push_req and InPortRead in the same cycle while empty: push only, pop ignored, count becomes 1.
  - No write-through bypass.
- Count update:
  - count changes by +1 on push only, -1 on pop only, 0 on both.
  - Flags derive from the registered count: InPortEmpty = (count==0), InPortFull = (count==DEPTH).
- Latency:
  - A word whose strobe edge is detected in cycle k appears on BusMuxIn_InPort in cycle k+1.
  - After a pop in cycle k, the next word (or 0) appears in cycle k+1.
- Bus output:
  - Combinational read of mem[rd_ptr], gated by ~InPortEmpty.
  - Stale array contents are never visible.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count is used for full/empty, so there is no pointer ambiguity.

Optional Feature:
- Macro: INPORT_OVF_STICKY_EN.
- Defined: InPortOverflow sets on any dropped push and stays 1 until clear.
- Undefined: InPortOverflow is a one-cycle pulse, high only in the cycle after a dropped push (registered), then returns to 0.
- FIFO data behaviour is identical either way.

Decomposition:
- Shared package in_port_pkg:
  - DATA_W default.
  - Pointer width function clog2(DEPTH).
  - Count width constant.
- One sub-module, in_port_edge_det: strobe register and push_req generation, with reset value 1.
- FIFO storage, pointers and flags stay in in_port_fifo.

Test Plan:
- Reset and empty read: assert clear 2 cycles, then pulse InPortRead with no strobes -> BusMuxIn_InPort=0, InPortEmpty=1, InPortCount=0, no state change.
- Ordered fill and drain: strobe ExtData=0x11, 0x22, 0x33 (ExtStrobe low between each) -> count=3, head=0x11. Three pops -> head 0x22, 0x33, then 0, and InPortEmpty=1.
- Full and overflow: push 0xA0..0xA3 -> InPortFull=1. Push 0xA4 -> dropped, count stays 4, InPortOverflow=1 (sticky stays 1; non-sticky drops to 0 next cycle). Draining yields 0xA0..0xA3 only.
- Simultaneous push and pop when full: with 4 words held, strobe edge with 0xB4 plus InPortRead -> count stays 4, no overflow, head=0xA1. The tail read after draining is 0xB4.
- Held strobe and clear: hold ExtStrobe=1 for 5 cycles -> exactly 1 word pushed. Assert clear while ExtStrobe is still 1, then release clear -> count=0 and no push until ExtStrobe goes 0 then 1.
- Wrap-around: 10 cycles of alternating push/pop of 0xC0..0xC9 -> every word is read back in order, count never exceeds 1, pointers wrap past DEPTH without error.
